// File: rtl/decode_nwide_pkg.sv
// Shared types, defaults and helpers for the N-wide RISC-V decoder.
// Holds the packet/uop structs and the per-lane decode function.
package decode_nwide_pkg;

  localparam int NDEC_DFLT       = 2;
  localparam int NREN_DFLT       = 2;
  localparam int UOPQ_DEPTH_DFLT = 8;

  typedef enum logic [1:0] {
    OP_INVD,
    OP_ZERO,
    OP_REG,
    OP_IMM
  } t_optype;

  typedef enum logic {
    SZ_8B,
    SZ_4B
  } t_opsize;

  typedef enum logic [2:0] {
    IF_R,
    IF_I,
    IF_S,
    IF_B,
    IF_U,
    IF_J,
    IF_ILL
  } t_ifmt;

  typedef struct packed {
    t_optype    typ;
    logic [4:0] num;
    t_opsize    sz;
  } t_opnd;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [15:0] simid;
  } t_instr_pkt;

  typedef struct packed {
    logic        valid;
    logic [6:0]  opcode;
    t_ifmt       ifmt;
    logic [63:0] pc;
    logic [15:0] simid;
    t_opnd       dst;
    t_opnd       src1;
    t_opnd       src2;
    logic [63:0] imm64;
  } t_uinstr;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int k = 0; k < 32; k++) c += 32'(v[k]);
    return c;
  endfunction

  // Contiguous from bit 0: of the form 0..01..1 (or zero).
  function automatic logic is_contig(input logic [31:0] v);
    return ((v + 32'd1) & v) == 32'd0;
  endfunction

  function automatic t_opnd reg_op(input logic [4:0] n, input t_opsize sz);
    t_opnd o;
    o.typ = OP_REG;
    o.num = n;
    o.sz  = sz;
    return o;
  endfunction

  function automatic t_uinstr decode_rv_instr(input t_instr_pkt p);
    t_uinstr    u;
    logic [31:0] i;
    logic [4:0]  op5;
    t_opsize     sz;
    logic        std, is_r, is_ia, is_io, is_b, is_s, is_j, is_u;
    i   = p.instr;
    op5 = i[6:2];
    std = (i[1:0] == 2'b11);
    sz  = i[3] ? SZ_4B : SZ_8B;
    is_r  = std & (op5 == 5'b01100 || op5 == 5'b01110);
    is_ia = std & (op5 == 5'b00100 || op5 == 5'b00110);
    is_io = std & (op5 == 5'b00000 || op5 == 5'b11001);
    is_b  = std & (op5 == 5'b11000);
    is_s  = std & (op5 == 5'b01000);
    is_j  = std & (op5 == 5'b11011);
    is_u  = std & (op5 == 5'b00101 || op5 == 5'b01101);
    u        = '0;
    u.opcode = i[6:0];
    u.pc     = p.pc;
    u.simid  = p.simid;
    u.ifmt   = IF_ILL;
    unique case (1'b1)
      is_r: begin
        u.ifmt = IF_R;
        u.dst  = reg_op(i[11:7], sz);
        u.src1 = reg_op(i[19:15], sz);
        u.src2 = reg_op(i[24:20], sz);
      end
      is_ia, is_io: begin
        u.ifmt  = IF_I;
        u.dst   = reg_op(i[11:7], sz);
        u.src1  = reg_op(i[19:15], sz);
        u.imm64 = {{52{i[31]}}, i[31:20]};
        if (is_ia) u.src2.typ = OP_IMM;
      end
      is_b: begin
        u.ifmt  = IF_B;
        u.src1  = reg_op(i[19:15], SZ_8B);
        u.src2  = reg_op(i[24:20], SZ_8B);
        u.imm64 = {{51{i[31]}}, i[31], i[7],
                   i[30:25], i[11:8], 1'b0};
      end
      is_s: u.ifmt = IF_S;
      is_j: u.ifmt = IF_J;
      is_u: u.ifmt = IF_U;
      default: u.ifmt = IF_ILL;
    endcase
    if (u.src1.typ == OP_REG && u.src1.num == '0)
      u.src1.typ = OP_ZERO;
    if (u.src2.typ == OP_REG && u.src2.num == '0)
      u.src2.typ = OP_ZERO;
    if (u.dst.typ == OP_REG && u.dst.num == '0)
      u.dst.typ = OP_INVD;
    return u;
  endfunction

endpackage

// File: rtl/decode_nwide_mfifo.sv
// Multi-push / multi-pop circular buffer (gen_mfifo) feeding rename.
// Pointers wrap by natural overflow; flush drops everything.
module gen_mfifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8,
  parameter int  NPUSH = 2,
  parameter int  NPOP  = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PCW   = $clog2(NPUSH + 1),
  localparam int QCW   = $clog2(NPOP + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [PCW-1:0]       push_cnt,
  input  T     [NPUSH-1:0]     push_data,
  input  logic [QCW-1:0]       pop_cnt,
  output T     [NPOP-1:0]      pop_data,
  output logic [CW-1:0]        occ
);

  localparam int PW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      occ    <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_cnt);
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      occ    <= occ + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      for (int i = 0; i < NPUSH; i++)
        if (i < int'(push_cnt))
          mem[wr_ptr + PW'(i)] <= push_data[i];
    end
  end

  // Read is combinational, so a same-slot push returns the old entry.
  always_comb begin
    for (int j = 0; j < NPOP; j++)
      pop_data[j] = mem[rd_ptr + PW'(j)];
  end

  a_occ_max: assert property (@(posedge clk) disable iff (reset)
    int'(occ) <= DEPTH);
  a_no_under: assert property (@(posedge clk) disable iff (reset)
    int'(pop_cnt) <= int'(occ));
  a_no_over: assert property (@(posedge clk) disable iff (reset)
    int'(occ) + int'(push_cnt) - int'(pop_cnt) <= DEPTH);

endmodule

// File: rtl/decode_nwide.sv
// N-wide decode plus uop queue between fetch and rename.
// Optional same-cycle bypass to rename under DECODE_BYPASS_EN.
module decode_nwide
  import decode_nwide_pkg::*;
#(
  parameter int NDEC       = NDEC_DFLT,
  parameter int NREN       = NREN_DFLT,
  parameter int UOPQ_DEPTH = UOPQ_DEPTH_DFLT,
  localparam int CW        = $clog2(UOPQ_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   br_mispred_rb1,
  input  logic [NDEC-1:0]        valid_fe1,
  input  t_instr_pkt [NDEC-1:0]  instr_fe1,
  output logic                   fe_ready_de0,
  output t_uinstr [NDEC-1:0]     uinstr_de0,
  input  logic                   rename_ready_rn0,
  output logic [NREN-1:0]        valid_de1,
  output t_uinstr [NREN-1:0]     uinstr_de1,
  output logic [CW-1:0]          uopq_occ_de1
);

  localparam int DW = $clog2(NDEC + 1);
  localparam int RW = $clog2(NREN + 1);
  localparam int LW = (NDEC > NREN) ? NDEC : NREN;

  t_uinstr [LW-1:0]   dec;
  t_uinstr [NDEC-1:0] push_data;
  t_uinstr [NREN-1:0] pop_data;
  logic [DW-1:0]      in_cnt, bp_cnt, push_cnt;
  logic [RW-1:0]      pop_cnt;
  logic [CW-1:0]      occ;
  logic               accept;

  always_comb begin
    dec = '0;
    for (int i = 0; i < NDEC; i++) begin
      dec[i]       = decode_rv_instr(instr_fe1[i]);
      dec[i].valid = valid_fe1[i];
    end
    if (reset) dec = '0;
  end

  assign uinstr_de0   = dec[NDEC-1:0];
  assign uopq_occ_de1 = occ;

  // Conservative: only registered occupancy, same-cycle pops ignored.
  assign fe_ready_de0 = ~reset &
    ((CW'(UOPQ_DEPTH) - occ) >= CW'(NDEC));
  assign accept = fe_ready_de0 & ~br_mispred_rb1;
  assign in_cnt = DW'(popcount(32'(valid_fe1)));

`ifdef DECODE_BYPASS_EN
  logic byp;
  assign byp    = accept & rename_ready_rn0 & (occ == '0);
  assign bp_cnt = !byp ? '0 :
    DW'((int'(in_cnt) > NREN) ? NREN : int'(in_cnt));
`else
  assign bp_cnt = '0;
`endif

  assign push_cnt = accept ? (in_cnt - bp_cnt) : '0;

  // Bypassed lanes skip the queue; the rest shift down to slot 0.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < NDEC; i++)
      for (int k = 0; k < NDEC; k++)
        if (k == i + int'(bp_cnt)) push_data[i] = dec[k];
  end

  assign pop_cnt =
    (rename_ready_rn0 & ~br_mispred_rb1 & ~reset) ?
    RW'((int'(occ) > NREN) ? NREN : int'(occ)) : '0;

  gen_mfifo #(
    .T     (t_uinstr),
    .DEPTH (UOPQ_DEPTH),
    .NPUSH (NDEC),
    .NPOP  (NREN)
  ) u_uopq (
    .clk       (clk),
    .reset     (reset),
    .flush     (br_mispred_rb1),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .pop_data  (pop_data),
    .occ       (occ)
  );

  always_comb begin
    valid_de1  = '0;
    uinstr_de1 = pop_data;
    for (int j = 0; j < NREN; j++) begin
      if (bp_cnt != '0) begin
        uinstr_de1[j] = dec[j];
        valid_de1[j]  = (j < int'(bp_cnt));
      end else begin
        valid_de1[j]  = (j < int'(pop_cnt));
      end
      uinstr_de1[j].valid = valid_de1[j];
    end
  end

  a_fe_contig: assert property (@(posedge clk) disable iff (reset)
    is_contig(32'(valid_fe1)));
  a_de_contig: assert property (@(posedge clk) disable iff (reset)
    is_contig(32'(valid_de1)));
  a_fe_proto: assert property (@(posedge clk) disable iff (reset)
    !(|valid_fe1) || fe_ready_de0);

endmodule

// File: tb/tb_decode_nwide.sv
// Directed self-checking bench for decode_nwide (NDEC=2, NREN=2, DEPTH=8).
// Adds a NDEC=4 bypass instance when DECODE_BYPASS_EN is defined.
module tb_decode_nwide;
  import decode_nwide_pkg::*;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'hFFF00013;
  localparam logic [31:0] I_BEQ  = 32'hFE208EE3;
  localparam logic [31:0] I_ADDW = 32'h007302BB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic rr = 1'b0;
  logic [1:0] vfe = '0;
  t_instr_pkt [1:0] ife = '0;
  logic fe_ready;
  t_uinstr [1:0] de0;
  logic [1:0] vde1;
  t_uinstr [1:0] de1;
  logic [3:0] occ;

  int errors = 0;
  int checks = 0;
  int exp_occ;
  int nxt;
  int k;

  always #5 clk = ~clk;

  decode_nwide #(.NDEC(2), .NREN(2), .UOPQ_DEPTH(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .br_mispred_rb1   (flush),
    .valid_fe1        (vfe),
    .instr_fe1        (ife),
    .fe_ready_de0     (fe_ready),
    .uinstr_de0       (de0),
    .rename_ready_rn0 (rr),
    .valid_de1        (vde1),
    .uinstr_de1       (de1),
    .uopq_occ_de1     (occ)
  );

`ifdef DECODE_BYPASS_EN
  logic b_rr = 1'b0;
  logic [3:0] b_vfe = '0;
  t_instr_pkt [3:0] b_ife = '0;
  logic b_ready;
  t_uinstr [3:0] b_de0;
  logic [1:0] b_vde1;
  t_uinstr [1:0] b_de1;
  logic [3:0] b_occ;

  decode_nwide #(.NDEC(4), .NREN(2), .UOPQ_DEPTH(8)) dut_b (
    .clk              (clk),
    .reset            (reset),
    .br_mispred_rb1   (flush),
    .valid_fe1        (b_vfe),
    .instr_fe1        (b_ife),
    .fe_ready_de0     (b_ready),
    .uinstr_de0       (b_de0),
    .rename_ready_rn0 (b_rr),
    .valid_de1        (b_vde1),
    .uinstr_de1       (b_de1),
    .uopq_occ_de1     (b_occ)
  );
`endif

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic t_instr_pkt pkt(input logic [31:0] ins,
                                     input logic [63:0] pc,
                                     input logic [15:0] id);
    t_instr_pkt p;
    p.instr = ins;
    p.pc    = pc;
    p.simid = id;
    return p;
  endfunction

  initial begin
    // Reset: decode outputs zeroed even with valid packets present.
    vfe    = 2'b11;
    ife[0] = pkt(I_ADD, 64'h10, 16'h1);
    ife[1] = pkt(I_ADD, 64'h14, 16'h2);
    tick;
    tick;
    check("rst_de0", 64'(de0 === '0), 64'h1);
    check("rst_vde1", 64'(vde1), 64'h0);
    check("rst_ready", 64'(fe_ready), 64'h0);
    vfe   = '0;
    reset = 1'b0;
    tick;
    check("rst_occ", 64'(occ), 64'h0);
    check("rst_ready_up", 64'(fe_ready), 64'h1);

    // Two ADDs with rename ready.
    rr     = 1'b1;
    vfe    = 2'b11;
    ife[0] = pkt(I_ADD, 64'h100, 16'h11);
    ife[1] = pkt(I_ADD, 64'h104, 16'h12);
    #1;
    check("add_dst", 64'(de0[0].dst.num), 64'h3);
    check("add_dst_t", 64'(de0[0].dst.typ), 64'(OP_REG));
    check("add_src2", 64'(de0[0].src2.num), 64'h2);
    check("add_sz", 64'(de0[0].dst.sz), 64'(SZ_8B));
`ifdef DECODE_BYPASS_EN
    check("t1_v", 64'(vde1), 64'h3);
    check("t1_pc0", de1[0].pc, 64'h100);
    check("t1_pc1", de1[1].pc, 64'h104);
    tick;
    vfe = '0;
    #1;
    check("t1_occ", 64'(occ), 64'h0);
`else
    check("t1_v_early", 64'(vde1), 64'h0);
    tick;
    vfe = '0;
    #1;
    check("t1_v", 64'(vde1), 64'h3);
    check("t1_pc0", de1[0].pc, 64'h100);
    check("t1_pc1", de1[1].pc, 64'h104);
    check("t1_occ", 64'(occ), 64'h2);
`endif
    tick;
    check("t1_drain", 64'(occ), 64'h0);
    check("t1_idle", 64'(vde1), 64'h0);

    // Backpressure: rename stalled, fill until not ready.
    rr      = 1'b0;
    exp_occ = 0;
    k       = 0;
    for (int c = 0; c < 6; c++) begin
      check("bp_occ", 64'(occ), 64'(exp_occ));
      check("bp_ready", 64'(fe_ready), 64'(exp_occ <= 6));
      if (exp_occ <= 6) begin
        vfe     = 2'b11;
        ife[0]  = pkt(I_ADD, 64'h200 + 64'(8 * k), 16'(k));
        ife[1]  = pkt(I_ADD, 64'h204 + 64'(8 * k), 16'(k));
        exp_occ += 2;
        k++;
      end else begin
        vfe = '0;
      end
      tick;
    end
    vfe = '0;
    check("bp_full", 64'(occ), 64'h8);
    check("bp_notready", 64'(fe_ready), 64'h0);
    rr = 1'b1;
    for (int p = 0; p < 4; p++) begin
      #1;
      check("bp_pop_v", 64'(vde1), 64'h3);
      check("bp_pop_pc0", de1[0].pc, 64'h200 + 64'(8 * p));
      check("bp_pop_pc1", de1[1].pc, 64'h204 + 64'(8 * p));
      tick;
    end
    check("bp_empty", 64'(occ), 64'h0);

    // Single-lane stream across pointer wraps.
    nxt = 0;
    for (int c = 0; c < 24; c++) begin
      if (c < 20) begin
        vfe    = 2'b01;
        ife[0] = pkt(I_ADD, 64'h1000 + 64'(c), 16'(c));
      end else begin
        vfe = '0;
      end
      #1;
      if (vde1[0]) begin
        check("wrap_pc", de1[0].pc, 64'h1000 + 64'(nxt));
        nxt++;
      end
      check("wrap_v1", 64'(vde1[1]), 64'h0);
      check("wrap_occ", 64'(occ <= 4'd1), 64'h1);
      tick;
    end
    check("wrap_cnt", 64'(nxt), 64'd20);

    // Flush with five queued and two incoming.
    rr     = 1'b0;
    vfe    = 2'b11;
    ife[0] = pkt(I_ADD, 64'h2000, 16'h20);
    ife[1] = pkt(I_ADD, 64'h2004, 16'h21);
    tick;
    tick;
    vfe = 2'b01;
    tick;
    check("fl_occ5", 64'(occ), 64'h5);
    flush  = 1'b1;
    rr     = 1'b1;
    vfe    = 2'b11;
    ife[0] = pkt(I_ADD, 64'h2100, 16'hBAD0);
    ife[1] = pkt(I_ADD, 64'h2104, 16'hBAD1);
    #1;
    check("fl_v", 64'(vde1), 64'h0);
    tick;
    flush = 1'b0;
    vfe   = '0;
    #1;
    check("fl_occ0", 64'(occ), 64'h0);
    check("fl_v_next", 64'(vde1), 64'h0);
    tick;
    check("fl_v_quiet", 64'(vde1), 64'h0);
    rr     = 1'b0;
    vfe    = 2'b01;
    ife[0] = pkt(I_ADD, 64'h3000, 16'h33);
    tick;
    vfe = '0;
    rr  = 1'b1;
    #1;
    check("fl_post_v", 64'(vde1), 64'h1);
    check("fl_post_id", 64'(de1[0].simid), 64'h33);
    tick;
    check("fl_post_occ", 64'(occ), 64'h0);

    // Decode corner cases (lanes not valid, so nothing is pushed).
    vfe    = '0;
    ife[0] = pkt(I_ADDI, 64'h40, 16'h40);
    ife[1] = pkt(I_BEQ, 64'h44, 16'h41);
    #1;
    check("addi_dst", 64'(de0[0].dst.typ), 64'(OP_INVD));
    check("addi_src1", 64'(de0[0].src1.typ), 64'(OP_ZERO));
    check("addi_src2", 64'(de0[0].src2.typ), 64'(OP_IMM));
    check("addi_imm", de0[0].imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_valid", 64'(de0[0].valid), 64'h0);
    check("beq_imm", de0[1].imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    check("beq_dst", 64'(de0[1].dst.typ), 64'(OP_INVD));
    check("beq_src1", 64'(de0[1].src1.num), 64'h1);
    check("beq_src2", 64'(de0[1].src2.num), 64'h2);
    check("beq_fmt", 64'(de0[1].ifmt), 64'(IF_B));
    ife[0] = pkt(I_ADDW, 64'h48, 16'h42);
    #1;
    check("addw_sz", 64'(de0[0].dst.sz), 64'(SZ_4B));
    check("addw_dst", 64'(de0[0].dst.num), 64'h5);
    tick;

`ifdef DECODE_BYPASS_EN
    // Bypass: three lanes into an empty queue, two leave at once.
    b_rr     = 1'b1;
    b_vfe    = 4'b0111;
    b_ife[0] = pkt(I_ADD, 64'h600, 16'h60);
    b_ife[1] = pkt(I_ADD, 64'h604, 16'h61);
    b_ife[2] = pkt(I_ADD, 64'h608, 16'h62);
    #1;
    check("byp_v", 64'(b_vde1), 64'h3);
    check("byp_pc0", b_de1[0].pc, 64'h600);
    check("byp_pc1", b_de1[1].pc, 64'h604);
    tick;
    b_vfe = '0;
    #1;
    check("byp_occ", 64'(b_occ), 64'h1);
    check("byp_rest_v", 64'(b_vde1), 64'h1);
    check("byp_rest_pc", b_de1[0].pc, 64'h608);
    tick;
    check("byp_empty", 64'(b_occ), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
